fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks IDLE -> FETCH -> WAIT_MEM -> DECODE -> EXECUTE
// and issues the PC/IR strobes that drive an external program counter and instruction register.
module fetch_sequencer #(
    parameter int unsigned ROM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    input  logic [7:0]  pc,
    output logic        pc_inc_en,
    output logic        pc_load,
    output logic [7:0]  pc_load_value,
    output logic        ir_load,
    output logic        busy,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_MEM = 3'd2,
        DECODE   = 3'd3,
        EXECUTE  = 3'd4,
        HALT     = 3'd5
    } state_e;

    // Last wait-counter value before leaving WAIT_MEM; unused when ROM_WAIT is 0.
    localparam logic [2:0] WAIT_LAST = (ROM_WAIT == 0) ? 3'd0 : 3'(ROM_WAIT - 1);

    state_e      state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic        retire;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wait_cnt_q    <= 3'd0;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        retire        = 1'b0;
        pc_inc_en     = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = 8'h00;
        ir_load       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                wait_cnt_d = 3'd0;
                state_d    = (ROM_WAIT == 0) ? DECODE : WAIT_MEM;
            end
            WAIT_MEM: begin
                if (wait_cnt_q == WAIT_LAST) state_d = DECODE;
                else                         wait_cnt_d = wait_cnt_q + 3'd1;
            end
            DECODE: begin
                ir_load = 1'b1;
                state_d = EXECUTE;
            end
            EXECUTE: begin
                // Exit priority: stall, halt, branch, end of ROM, then sequential fall-through.
                if (stall) begin
                    state_d = EXECUTE;
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (branch_taken) begin
                    pc_load       = 1'b1;
                    pc_load_value = branch_target;
                    retire        = 1'b1;
                    state_d       = FETCH;
                end else if (pc == 8'hFF) begin
                    retire  = 1'b1;
                    state_d = HALT;
                end else begin
                    pc_inc_en = 1'b1;
                    retire    = 1'b1;
                    state_d   = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        instr_count_d = instr_count_q;
        if (retire && (instr_count_q != 16'hFFFF)) instr_count_d = instr_count_q + 16'd1;
    end

    assign busy        = (state_q == FETCH) || (state_q == WAIT_MEM) ||
                         (state_q == DECODE) || (state_q == EXECUTE);
    assign halted      = (state_q == HALT);
    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares against the selected instance (ROM_WAIT = 1, 7, 0).
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, start, stall, halt_req, branch_taken;
    logic [7:0]  branch_target, pc;

    logic        inc1, load1, ir1, busy1, halt1;
    logic [7:0]  val1;
    logic [2:0]  st1;
    logic [15:0] cnt1;
    logic        inc7, load7, ir7, busy7, halt7;
    logic [7:0]  val7;
    logic [2:0]  st7;
    logic [15:0] cnt7;
    logic        inc0, load0, ir0, busy0, halt0;
    logic [7:0]  val0;
    logic [2:0]  st0;
    logic [15:0] cnt0;

    int checks = 0;
    int errors = 0;
    int stepNo = 0;

    typedef struct {
        int          which;
        int          stepId;
        logic [2:0]  eState;
        logic        eInc, eLoad, eIr;
        logic [7:0]  eVal;
        logic [15:0] eCnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_sequencer #(.ROM_WAIT(1)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .halt_req(halt_req),
        .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc),
        .pc_inc_en(inc1), .pc_load(load1), .pc_load_value(val1), .ir_load(ir1),
        .busy(busy1), .halted(halt1), .state(st1), .instr_count(cnt1));

    fetch_sequencer #(.ROM_WAIT(7)) u7 (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .halt_req(halt_req),
        .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc),
        .pc_inc_en(inc7), .pc_load(load7), .pc_load_value(val7), .ir_load(ir7),
        .busy(busy7), .halted(halt7), .state(st7), .instr_count(cnt7));

    fetch_sequencer #(.ROM_WAIT(0)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .halt_req(halt_req),
        .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc),
        .pc_inc_en(inc0), .pc_load(load0), .pc_load_value(val0), .ir_load(ir0),
        .busy(busy0), .halted(halt0), .state(st0), .instr_count(cnt0));

    // Drive one cycle of inputs just after the posedge and queue what that cycle should show.
    task automatic applyStimulus(input int which, input logic rstN, input logic st, input logic sl,
                                 input logic hr, input logic bt, input logic [7:0] tgt,
                                 input logic [7:0] pcv, input logic [2:0] eState,
                                 input logic eInc, input logic eLoad, input logic eIr,
                                 input logic [15:0] eCnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n       = rstN;
        start         = st;
        stall         = sl;
        halt_req      = hr;
        branch_taken  = bt;
        branch_target = tgt;
        pc            = pcv;
        stepNo++;
        if (which != 0) begin
            e.which  = which;
            e.stepId = stepNo;
            e.eState = eState;
            e.eInc   = eInc;
            e.eLoad  = eLoad;
            e.eIr    = eIr;
            e.eVal   = eLoad ? tgt : 8'h00;
            e.eCnt   = eCnt;
            sb.push_back(e);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [32:0] act, req;
        logic        eBusy, eHalted;
        eBusy   = (e.eState >= 3'd1) && (e.eState <= 3'd4);
        eHalted = (e.eState == 3'd5);
        req = {e.eState, e.eInc, e.eLoad, e.eVal, e.eIr, eBusy, eHalted, e.eCnt};
        case (e.which)
            1:       act = {st1, inc1, load1, val1, ir1, busy1, halt1, cnt1};
            2:       act = {st7, inc7, load7, val7, ir7, busy7, halt7, cnt7};
            default: act = {st0, inc0, load0, val0, ir0, busy0, halt0, cnt0};
        endcase
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL step%0d dut%0d: got {state,inc,load,val,ir,busy,halted,cnt}=%h, required %h",
                     e.stepId, e.which, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) checkOutput(sb.pop_front());
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
        branch_taken = 1'b0; branch_target = 8'h00; pc = 8'h00;
        repeat (2) @(posedge clk);

        // ROM_WAIT=1: reset, two normal-length instructions, branch, stall then halt.
        applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 16'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 16'd0);
        applyStimulus(1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 16'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 3'd1, 0, 0, 0, 16'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 3'd2, 0, 0, 0, 16'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 3'd3, 0, 0, 1, 16'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 3'd4, 1, 0, 0, 16'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h01, 3'd1, 0, 0, 0, 16'd1);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h01, 3'd2, 0, 0, 0, 16'd1);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h01, 3'd3, 0, 0, 1, 16'd1);
        applyStimulus(1, 1, 0, 0, 0, 1, 8'h40, 8'h01, 3'd4, 0, 1, 0, 16'd1);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h40, 3'd1, 0, 0, 0, 16'd2);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h40, 3'd2, 0, 0, 0, 16'd2);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h40, 3'd3, 0, 0, 1, 16'd2);
        applyStimulus(1, 1, 0, 1, 1, 1, 8'h22, 8'h40, 3'd4, 0, 0, 0, 16'd2);
        applyStimulus(1, 1, 0, 1, 0, 0, 8'h00, 8'h40, 3'd4, 0, 0, 0, 16'd2);
        applyStimulus(1, 1, 0, 1, 0, 1, 8'h22, 8'h40, 3'd4, 0, 0, 0, 16'd2);
        applyStimulus(1, 1, 0, 0, 1, 1, 8'h22, 8'h40, 3'd4, 0, 0, 0, 16'd2);
        applyStimulus(1, 1, 1, 0, 0, 0, 8'h00, 8'h40, 3'd5, 0, 0, 0, 16'd2);
        applyStimulus(1, 1, 1, 0, 0, 1, 8'h33, 8'h40, 3'd5, 0, 0, 0, 16'd2);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'h40, 3'd5, 0, 0, 0, 16'd2);

        // ROM_WAIT=1: leave HALT by reset, then end-of-ROM with and without a branch.
        applyStimulus(1, 0, 1, 0, 0, 0, 8'h00, 8'hFF, 3'd5, 0, 0, 0, 16'd2);
        applyStimulus(1, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 3'd0, 0, 0, 0, 16'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'hFF, 3'd1, 0, 0, 0, 16'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'hFF, 3'd2, 0, 0, 0, 16'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'hFF, 3'd3, 0, 0, 1, 16'd0);
        applyStimulus(1, 1, 0, 0, 0, 1, 8'h10, 8'hFF, 3'd4, 0, 1, 0, 16'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'hFF, 3'd1, 0, 0, 0, 16'd1);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'hFF, 3'd2, 0, 0, 0, 16'd1);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'hFF, 3'd3, 0, 0, 1, 16'd1);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'hFF, 3'd4, 0, 0, 0, 16'd1);
        applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, 8'hFF, 3'd5, 0, 0, 0, 16'd2);
        applyStimulus(1, 1, 1, 0, 1, 0, 8'h00, 8'h00, 3'd5, 0, 0, 0, 16'd2);

        // ROM_WAIT=7: full seven-cycle wait, then reset in the middle of the next wait.
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h05, 3'd0, 0, 0, 0, 16'd0);
        applyStimulus(2, 1, 1, 0, 0, 0, 8'h00, 8'h05, 3'd0, 0, 0, 0, 16'd0);
        applyStimulus(2, 1, 0, 0, 0, 0, 8'h00, 8'h05, 3'd1, 0, 0, 0, 16'd0);
        for (int i = 0; i < 7; i++)
            applyStimulus(2, 1, 0, 0, 0, 0, 8'h00, 8'h05, 3'd2, 0, 0, 0, 16'd0);
        applyStimulus(2, 1, 0, 0, 0, 0, 8'h00, 8'h05, 3'd3, 0, 0, 1, 16'd0);
        applyStimulus(2, 1, 0, 0, 0, 0, 8'h00, 8'h05, 3'd4, 1, 0, 0, 16'd0);
        applyStimulus(2, 1, 0, 0, 0, 0, 8'h00, 8'h06, 3'd1, 0, 0, 0, 16'd1);
        applyStimulus(2, 1, 0, 0, 0, 0, 8'h00, 8'h06, 3'd2, 0, 0, 0, 16'd1);
        applyStimulus(2, 1, 0, 0, 0, 0, 8'h00, 8'h06, 3'd2, 0, 0, 0, 16'd1);
        applyStimulus(2, 0, 0, 0, 0, 0, 8'h00, 8'h06, 3'd2, 0, 0, 0, 16'd1);
        applyStimulus(2, 1, 0, 0, 0, 0, 8'h00, 8'h06, 3'd0, 0, 0, 0, 16'd0);
        applyStimulus(2, 1, 0, 0, 0, 0, 8'h00, 8'h06, 3'd0, 0, 0, 0, 16'd0);
        applyStimulus(2, 1, 1, 0, 0, 0, 8'h00, 8'h06, 3'd0, 0, 0, 0, 16'd0);
        applyStimulus(2, 1, 0, 0, 0, 0, 8'h00, 8'h06, 3'd1, 0, 0, 0, 16'd0);

        // ROM_WAIT=0: FETCH goes straight to DECODE, three-cycle instruction period.
        applyStimulus(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 16'd0);
        applyStimulus(3, 1, 1, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 16'd0);
        applyStimulus(3, 1, 0, 0, 0, 0, 8'h00, 8'h00, 3'd1, 0, 0, 0, 16'd0);
        applyStimulus(3, 1, 0, 0, 0, 0, 8'h00, 8'h00, 3'd3, 0, 0, 1, 16'd0);
        applyStimulus(3, 1, 0, 0, 0, 0, 8'h00, 8'h00, 3'd4, 1, 0, 0, 16'd0);
        applyStimulus(3, 1, 0, 0, 0, 0, 8'h00, 8'h01, 3'd1, 0, 0, 0, 16'd1);
        applyStimulus(3, 1, 0, 0, 0, 0, 8'h00, 8'h01, 3'd3, 0, 0, 1, 16'd1);
        applyStimulus(3, 1, 0, 0, 0, 0, 8'h00, 8'h01, 3'd4, 1, 0, 0, 16'd1);
        applyStimulus(3, 1, 0, 0, 0, 0, 8'h00, 8'h02, 3'd1, 0, 0, 0, 16'd2);

        // Give the monitor a bounded number of cycles to drain the scoreboard.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
